pipe_ctl: RTL and testbench
===========================

# pipe_ctl

Pipeline hazard and flush controller for the five-stage core. It sequences the front end and the decode stage's ID/EX register: it generates the hold and bubble controls (`stall_*`, `clear_*`) for the fetch PC, IF/ID and ID/EX registers. It makes these decisions from register dependences, multi-cycle MDU operations, data-memory wait states, taken branches and traps. It sits beside the decode stage and drives that stage's `stall` and `clear` inputs.

## Interface
- `FLUSH_CYCLES`, default 2: cycles IF/ID stays cleared after a trap while fetch redirects (legal range 1..7).
- `MDU_MAX_CYCLES`, default 64: MDU wait limit before `mdu_timeout` is raised.
- `clk` input, 1 bit: clock, rising edge.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `id_rs1`, `id_rs2` input, 5 bits each: source registers of the instruction in decode.
- `id_with_imm` input, 1 bit: decode instruction uses an immediate, so `id_rs2` is ignored.
- `id_valid` input, 1 bit: decode holds a real instruction.
- `ex_rd` input, 5 bits: destination register in EX.
- `ex_load` input, 1 bit: EX instruction is a load.
- `ex_valid` input, 1 bit: EX holds a real instruction.
- `mem_rd` input, 5 bits: destination register in MEM.
- `mem_valid` input, 1 bit: MEM holds a real instruction.
- `mem_busy` input, 1 bit: data memory wait state.
- `mdu_start` input, 1 bit: multi-cycle mul/div issued from EX this cycle.
- `mdu_done` input, 1 bit: MDU result valid.
- `bj_en` input, 1 bit: taken branch or jump resolved in EX.
- `trap_en` input, 1 bit: trap or exception return taken.
- `stall_pc` output, 1 bit: hold the fetch PC.
- `stall_ifid` output, 1 bit: hold the IF/ID register.
- `stall_idex` output, 1 bit: hold the ID/EX register (decode `stall`).
- `clear_ifid` output, 1 bit: bubble into IF/ID.
- `clear_idex` output, 1 bit: bubble into ID/EX (decode `clear`).
- `mdu_kill` output, 1 bit: abort the in-flight MDU operation.
- `mdu_timeout` output, 1 bit: sticky, MDU exceeded `MDU_MAX_CYCLES`.

## Operation
- State machine with three states, encoded in 2 bits:
  - **RUN**: normal flow.
  - **MDU_WAIT**: waiting on the MDU.
  - **TRAP_FLUSH**: fetch is redirecting after a trap.
- **Load-use hazard**: `id_valid & ex_valid & ex_load & ex_rd!=0 & (ex_rd==id_rs1 | (!id_with_imm & ex_rd==id_rs2))`. Register x0 never creates a hazard.
- **RUN outputs, in priority order**:
  1. `trap_en`: `clear_ifid=1`, `clear_idex=1`. Go to TRAP_FLUSH and load the counter with `FLUSH_CYCLES-1`.
  2. `bj_en`: `clear_ifid=1`, `clear_idex=1` for one cycle only. Stay in RUN.
  3. `mem_busy`: `stall_pc`, `stall_ifid` and `stall_idex` all 1.
  4. `mdu_start`: all three stalls 1. Go to MDU_WAIT and load the counter with 0.
  5. Load-use hazard: `stall_pc=1`, `stall_ifid=1`, `clear_idex=1`.
- **MDU_WAIT**:
  - All three stalls are 1 and the counter increments each cycle.
  - `mdu_done` returns the state to RUN; stalls drop in the same cycle.
  - If the counter reaches `MDU_MAX_CYCLES-1` without `mdu_done`, set `mdu_timeout`, pulse `mdu_kill` and return to RUN.
  - `trap_en` pulses `mdu_kill`, asserts both clears and goes to TRAP_FLUSH. The trap overrides `mdu_done` in the same cycle.
- **TRAP_FLUSH**:
  - `clear_ifid=1` and `stall_pc=0` while the counter counts down.
  - The state returns to RUN in the cycle after the counter reads 0.
  - A further `trap_en` reloads the counter.
  - `bj_en`, `mem_busy` and the hazard inputs are ignored.
- **Clear vs stall**: when a clear and a stall target the same register, the clear wins and that stall is forced to 0.
- **`mdu_timeout`**: cleared only by reset.

## Timing
- All outputs are combinational from the registered state/counter and the current inputs. There are no registered output delays.
- Load-use inserts exactly one bubble. The next cycle the load is in MEM and the hazard clears (with forwarding).
- A branch costs 2 cycles: the IF/ID and ID/EX contents are killed in the same cycle `bj_en` is high.
- A trap costs `FLUSH_CYCLES+1` cycles of IF/ID bubbles.
- `mdu_start` together with `mdu_done` in the same cycle: the start is taken, MDU_WAIT is entered, and the following `mdu_done` releases it.
- **Reset**:
  - While `rst_n` is low, all outputs are 0, the state is RUN, the counter is 0 and `mdu_timeout` is 0.
  - Reset asserted mid-MDU_WAIT or mid-TRAP_FLUSH returns to RUN immediately, with no `mdu_kill` pulse.

## Configuration
- `PIPE_CTL_FWD_EN` defined (forwarding present): only the load-use hazard stalls.
- Not defined, no forwarding:
  - The hazard also fires on any RAW against valid EX (`ex_rd`, load or not) or valid MEM (`mem_rd`), excluding x0.
  - Same response as load-use: `stall_pc=1`, `stall_ifid=1`, `clear_idex=1`, repeated each cycle until the writer leaves MEM.

## Test plan
- **Load-use, `PIPE_CTL_FWD_EN` defined**: `ex_load=1`, `ex_rd=5`, `id_rs1=5` → one cycle of `stall_pc`=`stall_ifid`=`clear_idex`=1. The next cycle, with `ex_load=0`, all outputs are 0. Repeat with `ex_rd=0` → no stall. Repeat with `id_with_imm=1` and the match on `id_rs2` only → no stall.
- **No forwarding, macro undefined**: an ALU op in EX writes x7 and decode reads x7 → two consecutive bubble cycles (EX, then MEM) before release.
- **MDU**:
  - `mdu_start`, then `mdu_done` 10 cycles later → stalls high for exactly 11 cycles, then RUN.
  - With `MDU_MAX_CYCLES=4` and no `mdu_done` → `mdu_kill` pulses on cycle 4 and `mdu_timeout` stays 1.
- **Trap**: `trap_en` during MDU_WAIT, `FLUSH_CYCLES=2` → `mdu_kill`=1 and both clears that cycle, then `clear_ifid`=1 for 2 more cycles, then RUN. A second `trap_en` mid-flush extends the flush.
- **Priority**: `bj_en`, `mem_busy` and a load-use hazard in the same cycle → only the clears are asserted and all stalls are 0.
- **Reset**: `rst_n` dropped asynchronously mid-TRAP_FLUSH → outputs go to 0 without waiting for a clock edge. After release, the state is RUN.

Source files
------------

// File: rtl/pipe_ctl_if.sv
// Pipeline-side hazard/flush signal bundle between the core stages and pipe_ctl.
// master = pipeline stages (drive status, receive stall/clear), slave = pipe_ctl.
interface pipe_ctl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_with_imm;
    logic       id_valid;
    logic [4:0] ex_rd;
    logic       ex_load;
    logic       ex_valid;
    logic [4:0] mem_rd;
    logic       mem_valid;
    logic       mem_busy;
    logic       mdu_start;
    logic       mdu_done;
    logic       bj_en;
    logic       trap_en;
    logic       stall_pc;
    logic       stall_ifid;
    logic       stall_idex;
    logic       clear_ifid;
    logic       clear_idex;
    logic       mdu_kill;
    logic       mdu_timeout;

    modport master (
        output id_rs1, id_rs2, id_with_imm, id_valid,
        output ex_rd, ex_load, ex_valid, mem_rd, mem_valid, mem_busy,
        output mdu_start, mdu_done, bj_en, trap_en,
        input  stall_pc, stall_ifid, stall_idex, clear_ifid, clear_idex,
        input  mdu_kill, mdu_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_with_imm, id_valid,
        input  ex_rd, ex_load, ex_valid, mem_rd, mem_valid, mem_busy,
        input  mdu_start, mdu_done, bj_en, trap_en,
        output stall_pc, stall_ifid, stall_idex, clear_ifid, clear_idex,
        output mdu_kill, mdu_timeout
    );
endinterface

// File: rtl/pipe_ctl.sv
// Hazard and flush controller driving fetch PC, IF/ID and ID/EX stall/clear controls.
// Define PIPE_CTL_FWD_EN when the datapath forwards; only load-use then stalls.
//
// state        | meaning
// S_RUN        | normal flow, hazards/branches/traps resolved by priority
// S_MDU_WAIT   | multi-cycle MDU op in EX, counter counts waited cycles
// S_TRAP_FLUSH | fetch redirecting after a trap, counter counts down to 0
module pipe_ctl #(
    parameter int FLUSH_CYCLES   = 2,
    parameter int MDU_MAX_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctl_if.slave  bus
);

    localparam int CNT_W = ($clog2(MDU_MAX_CYCLES) > 3) ? $clog2(MDU_MAX_CYCLES) : 3;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] MDU_LAST   = CNT_W'(MDU_MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_MDU_WAIT   = 2'd1,
        S_TRAP_FLUSH = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             timeout_q, timeout_set;

    logic ex_match, mem_match, load_use, hazard;
    logic sp, sif, sid, cif, cid, kill;

    assign ex_match  = (bus.ex_rd != 5'd0) &&
                       ((bus.ex_rd == bus.id_rs1) || (!bus.id_with_imm && (bus.ex_rd == bus.id_rs2)));
    assign mem_match = (bus.mem_rd != 5'd0) &&
                       ((bus.mem_rd == bus.id_rs1) || (!bus.id_with_imm && (bus.mem_rd == bus.id_rs2)));
    assign load_use  = bus.id_valid && bus.ex_valid && bus.ex_load && ex_match;

`ifdef PIPE_CTL_FWD_EN
    logic unused_mem;
    assign unused_mem = mem_match ^ bus.mem_valid;
    assign hazard     = load_use;
`else
    // Without forwarding every in-flight writer must drain past MEM first.
    assign hazard = load_use ||
                    (bus.id_valid && ((bus.ex_valid && ex_match) || (bus.mem_valid && mem_match)));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RUN;
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            timeout_q <= timeout_q | timeout_set;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        timeout_set = 1'b0;
        case (state)
            S_RUN: begin
                if (bus.trap_en) begin
                    state_nxt = S_TRAP_FLUSH;
                    cnt_nxt   = FLUSH_LOAD;
                end else if (!bus.bj_en && !bus.mem_busy && bus.mdu_start) begin
                    state_nxt = S_MDU_WAIT;
                    cnt_nxt   = '0;
                end
            end
            S_MDU_WAIT: begin
                if (bus.trap_en) begin
                    state_nxt = S_TRAP_FLUSH;
                    cnt_nxt   = FLUSH_LOAD;
                end else if (bus.mdu_done) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end else if (cnt == MDU_LAST) begin
                    state_nxt   = S_RUN;
                    cnt_nxt     = '0;
                    timeout_set = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_TRAP_FLUSH: begin
                if (bus.trap_en) begin
                    cnt_nxt = FLUSH_LOAD;
                end else if (cnt == '0) begin
                    state_nxt = S_RUN;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = S_RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        sp   = 1'b0;
        sif  = 1'b0;
        sid  = 1'b0;
        cif  = 1'b0;
        cid  = 1'b0;
        kill = 1'b0;
        case (state)
            S_RUN: begin
                if (bus.trap_en || bus.bj_en) begin
                    cif = 1'b1;
                    cid = 1'b1;
                end else if (bus.mem_busy || bus.mdu_start) begin
                    sp  = 1'b1;
                    sif = 1'b1;
                    sid = 1'b1;
                end else if (hazard) begin
                    sp  = 1'b1;
                    sif = 1'b1;
                    cid = 1'b1;
                end
            end
            S_MDU_WAIT: begin
                if (bus.trap_en) begin
                    kill = 1'b1;
                    cif  = 1'b1;
                    cid  = 1'b1;
                end else if (bus.mdu_done) begin
                    sp = 1'b0;
                end else if (cnt == MDU_LAST) begin
                    // Abandoned op: release the pipeline together with the kill.
                    kill = 1'b1;
                end else begin
                    sp  = 1'b1;
                    sif = 1'b1;
                    sid = 1'b1;
                end
            end
            S_TRAP_FLUSH: begin
                cif = 1'b1;
                cid = bus.trap_en;
            end
            default: begin
                sp = 1'b0;
            end
        endcase
    end

    // Outputs are forced low during reset so they drop without waiting for a clock.
    assign bus.stall_pc    = rst_n & sp;
    assign bus.stall_ifid  = rst_n & sif & ~cif;
    assign bus.stall_idex  = rst_n & sid & ~cid;
    assign bus.clear_ifid  = rst_n & cif;
    assign bus.clear_idex  = rst_n & cid;
    assign bus.mdu_kill    = rst_n & kill;
    assign bus.mdu_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctl.sv
// Directed self-checking bench for pipe_ctl: two instances (default and MDU_MAX_CYCLES=4).
// Output vector order: {stall_pc, stall_ifid, stall_idex, clear_ifid, clear_idex, mdu_kill, mdu_timeout}.
module tb_pipe_ctl;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   failed;

    pipe_ctl_if b ();
    pipe_ctl_if b4 ();

    pipe_ctl #(.FLUSH_CYCLES(2), .MDU_MAX_CYCLES(64)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    pipe_ctl #(.FLUSH_CYCLES(2), .MDU_MAX_CYCLES(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_LU    = 7'b1100100;
    localparam logic [6:0] O_STALL = 7'b1110000;
    localparam logic [6:0] O_CLR   = 7'b0001100;
    localparam logic [6:0] O_TRMDU = 7'b0001110;
    localparam logic [6:0] O_FLUSH = 7'b0001000;

    logic [6:0] out_m, out_4;
    assign out_m = {b.stall_pc, b.stall_ifid, b.stall_idex, b.clear_ifid, b.clear_idex,
                    b.mdu_kill, b.mdu_timeout};
    assign out_4 = {b4.stall_pc, b4.stall_ifid, b4.stall_idex, b4.clear_ifid, b4.clear_idex,
                    b4.mdu_kill, b4.mdu_timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_m();
        b.id_rs1 = 5'd0; b.id_rs2 = 5'd0; b.id_with_imm = 1'b0; b.id_valid = 1'b0;
        b.ex_rd = 5'd0; b.ex_load = 1'b0; b.ex_valid = 1'b0;
        b.mem_rd = 5'd0; b.mem_valid = 1'b0; b.mem_busy = 1'b0;
        b.mdu_start = 1'b0; b.mdu_done = 1'b0; b.bj_en = 1'b0; b.trap_en = 1'b0;
    endtask

    task automatic idle_4();
        b4.id_rs1 = 5'd0; b4.id_rs2 = 5'd0; b4.id_with_imm = 1'b0; b4.id_valid = 1'b0;
        b4.ex_rd = 5'd0; b4.ex_load = 1'b0; b4.ex_valid = 1'b0;
        b4.mem_rd = 5'd0; b4.mem_valid = 1'b0; b4.mem_busy = 1'b0;
        b4.mdu_start = 1'b0; b4.mdu_done = 1'b0; b4.bj_en = 1'b0; b4.trap_en = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic imm);
        idle_m();
        b.id_valid = 1'b1; b.id_rs1 = rs1; b.id_rs2 = rs2; b.id_with_imm = imm;
        b.ex_valid = 1'b1; b.ex_load = 1'b1; b.ex_rd = rd;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        idle_m();
        idle_4();
        rst_n = 1'b0;

        // Reset: outputs low even with active requests
        #2;
        b.trap_en = 1'b1; b.mem_busy = 1'b1; b4.mdu_start = 1'b1;
        #1;
        chk("reset_out", out_m, O_IDLE);
        chk("reset_out4", out_4, O_IDLE);
        idle_m(); idle_4();
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_reset_run", out_m, O_IDLE);

        // Load-use on rs1
        load_use(5'd5, 5'd5, 5'd0, 1'b0);
        #1 chk("lu_rs1", out_m, O_LU);
        tick();
        idle_m();
        b.id_valid = 1'b1; b.id_rs1 = 5'd5;
        #1 chk("lu_release", out_m, O_IDLE);
        tick();

        // x0 never hazards
        load_use(5'd0, 5'd0, 5'd0, 1'b0);
        #1 chk("lu_x0", out_m, O_IDLE);
        tick();

        // rs2 ignored with immediate, matched without
        load_use(5'd5, 5'd3, 5'd5, 1'b1);
        #1 chk("lu_imm_rs2", out_m, O_IDLE);
        b.id_with_imm = 1'b0;
        #1 chk("lu_rs2", out_m, O_LU);
        tick();

        // ALU RAW on x7: EX then MEM
        idle_m();
        b.id_valid = 1'b1; b.id_rs1 = 5'd7; b.ex_valid = 1'b1; b.ex_rd = 5'd7;
`ifdef PIPE_CTL_FWD_EN
        #1 chk("raw_ex", out_m, O_IDLE);
`else
        #1 chk("raw_ex", out_m, O_LU);
`endif
        tick();
        b.ex_valid = 1'b0; b.ex_rd = 5'd0; b.mem_valid = 1'b1; b.mem_rd = 5'd7;
`ifdef PIPE_CTL_FWD_EN
        #1 chk("raw_mem", out_m, O_IDLE);
`else
        #1 chk("raw_mem", out_m, O_LU);
`endif
        tick();
        b.mem_valid = 1'b0; b.mem_rd = 5'd0;
        #1 chk("raw_release", out_m, O_IDLE);
        tick();

        // Priority: branch over mem_busy and load-use
        load_use(5'd9, 5'd9, 5'd0, 1'b0);
        b.bj_en = 1'b1; b.mem_busy = 1'b1;
        #1 chk("prio_bj", out_m, O_CLR);
        tick();
        load_use(5'd9, 5'd9, 5'd0, 1'b0);
        b.mem_busy = 1'b1;
        #1 chk("prio_membusy", out_m, O_STALL);
        tick();
        idle_m();
        #1 chk("bj_one_cycle", out_m, O_IDLE);

        // MDU: start, 10 waiting cycles, then done
        b.mdu_start = 1'b1;
        #1 chk("mdu_start", out_m, O_STALL);
        for (int i = 0; i < 10; i++) begin
            tick();
            b.mdu_start = 1'b0;
            #1 chk($sformatf("mdu_wait%0d", i), out_m, O_STALL);
        end
        tick();
        b.mdu_done = 1'b1;
        #1 chk("mdu_done", out_m, O_IDLE);
        tick();
        b.mdu_done = 1'b0;
        #1 chk("mdu_back_run", out_m, O_IDLE);

        // start and done together: start wins, next done releases
        b.mdu_start = 1'b1; b.mdu_done = 1'b1;
        #1 chk("mdu_start_done", out_m, O_STALL);
        tick();
        b.mdu_start = 1'b0; b.mdu_done = 1'b0;
        #1 chk("mdu_sd_wait", out_m, O_STALL);
        tick();
        b.mdu_done = 1'b1;
        #1 chk("mdu_sd_done", out_m, O_IDLE);
        tick();
        idle_m();

        // Trap during MDU_WAIT overrides done; flush ignores bj/mem_busy
        b.mdu_start = 1'b1;
        tick();
        b.mdu_start = 1'b0;
        #1 chk("trap_pre_wait", out_m, O_STALL);
        tick();
        b.trap_en = 1'b1; b.mdu_done = 1'b1;
        #1 chk("trap_in_mdu", out_m, O_TRMDU);
        tick();
        idle_m();
        load_use(5'd4, 5'd4, 5'd0, 1'b0);
        b.bj_en = 1'b1; b.mem_busy = 1'b1;
        #1 chk("flush1_ignored", out_m, O_FLUSH);
        tick();
        idle_m();
        #1 chk("flush2", out_m, O_FLUSH);
        tick();
        #1 chk("flush_done", out_m, O_IDLE);

        // Second trap mid-flush reloads the counter
        b.trap_en = 1'b1;
        #1 chk("trap_run", out_m, O_CLR);
        tick();
        b.trap_en = 1'b0;
        #1 chk("ext_flush1", out_m, O_FLUSH);
        tick();
        b.trap_en = 1'b1;
        #1 chk("ext_retrap", out_m, O_CLR);
        tick();
        b.trap_en = 1'b0;
        #1 chk("ext_flush2", out_m, O_FLUSH);
        tick();
        #1 chk("ext_flush3", out_m, O_FLUSH);
        tick();
        #1 chk("ext_done", out_m, O_IDLE);

        // MDU timeout with MDU_MAX_CYCLES=4
        b4.mdu_start = 1'b1;
        #1 chk("to_start", out_4, O_STALL);
        for (int i = 0; i < 3; i++) begin
            tick();
            b4.mdu_start = 1'b0;
            #1 chk($sformatf("to_wait%0d", i), out_4, O_STALL);
        end
        tick();
        #1 chk("to_kill", {6'd0, b4.mdu_kill}, 7'd1);
        chk("to_not_yet", {6'd0, b4.mdu_timeout}, 7'd0);
        tick();
        #1 chk("to_sticky1", out_4, 7'b0000001);
        tick();
        #1 chk("to_sticky2", out_4, 7'b0000001);
        chk("main_no_timeout", out_m, O_IDLE);

        // Async reset mid-flush
        b.trap_en = 1'b1;
        tick();
        b.trap_en = 1'b0;
        #1 chk("rst_pre_flush", out_m, O_FLUSH);
        b.mem_busy = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk("rst_async_out", out_m, O_IDLE);
        chk("rst_async_out4", out_4, O_IDLE);
        idle_m();
        tick();
        #2 rst_n = 1'b1;
        #1 chk("rst_release", out_m, O_IDLE);
        tick();
        #1 chk("rst_state_run", out_m, O_IDLE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
